// File: rtl/button_conditioner_pkg.sv
// Shared game definitions: debounce FSM states and button index map.
package button_conditioner_pkg;

  // Per-channel debounce state; level is 1 only in HELD and RELEASE_WAIT.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Bit positions inside the 3-bit button bus.
  localparam int unsigned BTN_LEFT  = 0;
  localparam int unsigned BTN_RIGHT = 1;
  localparam int unsigned BTN_JUMP  = 2;
  localparam int unsigned BTN_COUNT = 3;

endpackage

// File: rtl/button_conditioner_channel.sv
// One conditioned input: synchronizer, debounce FSM with saturating counter,
// and a single-cycle pulse on each accepted 0->1 level change.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // The cycle that would bring the count to DEBOUNCE_CYCLES-1 takes the
  // transition instead, so the input has been sampled stable DEBOUNCE_CYCLES times.
  localparam int unsigned CNT_LAST = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 2 : 0;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   in_s;
  btn_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   level_dly_q;
  logic                   pulse_q;

  assign in_s    = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  assign pulse_o = pulse_q;

  // Synchronizer chain for the asynchronous raw input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= raw_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Debounce FSM; counter only advances below CNT_LAST so it can never wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_s) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!in_s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(CNT_LAST)) begin
            state_q <= HELD;
            cnt_q   <= '0;
            level_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        HELD: begin
          if (!in_s) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (in_s) begin
            state_q <= HELD;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(CNT_LAST)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  // Rising-level detector: pulse in the cycle after the level goes high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      level_dly_q <= level_q;
      pulse_q     <= level_q & ~level_dly_q;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the board buttons and slide switch into debounced levels and
// press pulses for the player and game-FSM blocks.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn_raw,
  input  logic       sw_raw,
  input  logic       game_active,
  output logic [2:0] btn_level,
  output logic       move_left_pulse,
  output logic       move_right_pulse,
  output logic       jump_pulse,
  output logic       start_pulse,
  output logic       slide_hold
);

  logic [BTN_COUNT-1:0] btn_pulse;
  logic                 sw_pulse_unused;

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_left (
    .clk_i   (clock),
    .rst_i   (reset),
    .raw_i   (btn_raw[BTN_LEFT]),
    .level_o (btn_level[BTN_LEFT]),
    .pulse_o (btn_pulse[BTN_LEFT])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_right (
    .clk_i   (clock),
    .rst_i   (reset),
    .raw_i   (btn_raw[BTN_RIGHT]),
    .level_o (btn_level[BTN_RIGHT]),
    .pulse_o (btn_pulse[BTN_RIGHT])
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_jump (
    .clk_i   (clock),
    .rst_i   (reset),
    .raw_i   (btn_raw[BTN_JUMP]),
    .level_o (btn_level[BTN_JUMP]),
    .pulse_o (btn_pulse[BTN_JUMP])
  );

  // The slide switch is a level control only; its pulse is discarded.
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_slide (
    .clk_i   (clock),
    .rst_i   (reset),
    .raw_i   (sw_raw),
    .level_o (slide_hold),
    .pulse_o (sw_pulse_unused)
  );

  // Left/right pass straight through; the player block arbitrates.
  assign move_left_pulse  = btn_pulse[BTN_LEFT];
  assign move_right_pulse = btn_pulse[BTN_RIGHT];

  // Start/jump steered by game_active in the pulse cycle; mutually exclusive.
  assign jump_pulse  = btn_pulse[BTN_JUMP] &  game_active;
  assign start_pulse = btn_pulse[BTN_JUMP] & ~game_active;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an 8-cycle debounce window.
module tb_button_conditioner;

  logic       clock;
  logic       reset;
  logic [2:0] btn_raw;
  logic       sw_raw;
  logic       game_active;
  logic [2:0] btn_level;
  logic       move_left_pulse;
  logic       move_right_pulse;
  logic       jump_pulse;
  logic       start_pulse;
  logic       slide_hold;

  int passed;
  int total;

  button_conditioner #(
    .DEBOUNCE_CYCLES (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_raw          (btn_raw),
    .sw_raw           (sw_raw),
    .game_active      (game_active),
    .btn_level        (btn_level),
    .move_left_pulse  (move_left_pulse),
    .move_right_pulse (move_right_pulse),
    .jump_pulse       (jump_pulse),
    .start_pulse      (start_pulse),
    .slide_hold       (slide_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    btn_raw = 3'b000;
    sw_raw  = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_reset();
    logic [3:0] pulses;
    reset = 1'b1;
    btn_raw = 3'b111;
    sw_raw = 1'b1;
    repeat (12) step();
    pulses = {move_left_pulse, move_right_pulse, jump_pulse, start_pulse};
    total++;
    if (btn_level !== 3'b000) $display("FAIL reset_btn_level: got %b expected 000", btn_level);
    else passed++;
    total++;
    if (pulses !== 4'b0000) $display("FAIL reset_pulses: got %b expected 0000", pulses);
    else passed++;
    total++;
    if (slide_hold !== 1'b0) $display("FAIL reset_slide_hold: got %b expected 0", slide_hold);
    else passed++;
    btn_raw = 3'b000;
    sw_raw = 1'b0;
    step();
    reset = 1'b0;
    repeat (15) step();
    total++;
    if (btn_level !== 3'b000) $display("FAIL post_reset_level: got %b expected 000", btn_level);
    else passed++;
  endtask

  task automatic test_left_hold();
    int n_left, n_other, first;
    n_left = 0; n_other = 0; first = -1;
    btn_raw[0] = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (move_left_pulse) begin
        n_left++;
        if (first < 0) first = cyc;
      end
      if (move_right_pulse || jump_pulse || start_pulse) n_other++;
      if (cyc == 9) begin
        total++;
        if (btn_level[0] !== 1'b0) $display("FAIL left_level_early: got %b expected 0", btn_level[0]);
        else passed++;
      end
      if (cyc == 10) begin
        total++;
        if (btn_level[0] !== 1'b1) $display("FAIL left_level_rise: got %b expected 1", btn_level[0]);
        else passed++;
      end
    end
    total++;
    if (n_left !== 1) $display("FAIL left_pulse_count: got %0d expected 1", n_left);
    else passed++;
    total++;
    if (first !== 11) $display("FAIL left_pulse_latency: got %0d expected 11", first);
    else passed++;
    total++;
    if (n_other !== 0) $display("FAIL left_other_pulses: got %0d expected 0", n_other);
    else passed++;
    btn_raw[0] = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (move_left_pulse) n_left++;
      if (cyc == 9) begin
        total++;
        if (btn_level[0] !== 1'b1) $display("FAIL left_release_early: got %b expected 1", btn_level[0]);
        else passed++;
      end
      if (cyc == 10) begin
        total++;
        if (btn_level[0] !== 1'b0) $display("FAIL left_release_fall: got %b expected 0", btn_level[0]);
        else passed++;
      end
    end
    total++;
    if (n_left !== 1) $display("FAIL left_release_pulse: got %0d expected 1", n_left);
    else passed++;
    settle();
  endtask

  task automatic test_glitch_right();
    int n_right, n_level;
    n_right = 0; n_level = 0;
    btn_raw[1] = 1'b1;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      step();
      if (cyc == 5) btn_raw[1] = 1'b0;
      if (move_right_pulse) n_right++;
      if (btn_level[1]) n_level++;
    end
    total++;
    if (n_right !== 0) $display("FAIL glitch_right_pulse: got %0d expected 0", n_right);
    else passed++;
    total++;
    if (n_level !== 0) $display("FAIL glitch_right_level: got %0d high cycles expected 0", n_level);
    else passed++;
    settle();
  endtask

  task automatic run_bounce(input logic active, output int n_start, output int n_jump,
                            output int first);
    logic [3:0] bounce;
    bounce = 4'b0101;
    n_start = 0; n_jump = 0; first = -1;
    game_active = active;
    btn_raw[2] = bounce[0];
    for (int cyc = 1; cyc <= 25; cyc++) begin
      step();
      if (cyc < 4) btn_raw[2] = bounce[cyc];
      else btn_raw[2] = 1'b1;
      if (start_pulse) n_start++;
      if (jump_pulse) n_jump++;
      if ((start_pulse || jump_pulse) && first < 0) first = cyc;
    end
    settle();
  endtask

  task automatic test_start_jump();
    int ns, nj, first;
    run_bounce(1'b0, ns, nj, first);
    total++;
    if (ns !== 1) $display("FAIL start_count: got %0d expected 1", ns);
    else passed++;
    total++;
    if (nj !== 0) $display("FAIL start_jump_leak: got %0d expected 0", nj);
    else passed++;
    total++;
    if (first !== 15) $display("FAIL start_latency: got %0d expected 15", first);
    else passed++;
    run_bounce(1'b1, ns, nj, first);
    total++;
    if (nj !== 1) $display("FAIL jump_count: got %0d expected 1", nj);
    else passed++;
    total++;
    if (ns !== 0) $display("FAIL jump_start_leak: got %0d expected 0", ns);
    else passed++;
    total++;
    if (first !== 15) $display("FAIL jump_latency: got %0d expected 15", first);
    else passed++;
    game_active = 1'b0;
  endtask

  task automatic test_simultaneous();
    int lc, rc, nl, nr;
    lc = -1; rc = -1; nl = 0; nr = 0;
    btn_raw[1:0] = 2'b11;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (move_left_pulse) begin nl++; if (lc < 0) lc = cyc; end
      if (move_right_pulse) begin nr++; if (rc < 0) rc = cyc; end
    end
    total++;
    if (lc !== 11) $display("FAIL both_left_cycle: got %0d expected 11", lc);
    else passed++;
    total++;
    if (rc !== 11) $display("FAIL both_right_cycle: got %0d expected 11", rc);
    else passed++;
    total++;
    if (nl + nr !== 2) $display("FAIL both_pulse_total: got %0d expected 2", nl + nr);
    else passed++;
    total++;
    if (btn_level !== 3'b011) $display("FAIL both_level: got %b expected 011", btn_level);
    else passed++;
    settle();
  endtask

  task automatic test_reset_press_wait();
    int n_left, first;
    logic [3:0] outs;
    n_left = 0; first = -1;
    btn_raw[0] = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      step();
      if (move_left_pulse) n_left++;
    end
    reset = 1'b1;
    step();
    outs = {move_left_pulse, move_right_pulse, jump_pulse, start_pulse};
    total++;
    if ({btn_level, slide_hold, outs} !== 8'h00)
      $display("FAIL rst_pw_outputs: got %b expected 00000000", {btn_level, slide_hold, outs});
    else passed++;
    step();
    if (move_left_pulse) n_left++;
    reset = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      if (move_left_pulse) begin n_left++; if (first < 0) first = cyc; end
    end
    total++;
    if (n_left !== 1) $display("FAIL rst_pw_pulse_count: got %0d expected 1", n_left);
    else passed++;
    total++;
    if (first !== 11) $display("FAIL rst_pw_latency: got %0d expected 11", first);
    else passed++;
    settle();
  endtask

  task automatic test_slide();
    int rises, falls, rise_cyc, n_pulse;
    logic prev;
    rises = 0; falls = 0; rise_cyc = -1; n_pulse = 0;
    prev = slide_hold;
    sw_raw = 1'b1;
    for (int cyc = 1; cyc <= 35; cyc++) begin
      step();
      if (cyc == 12) sw_raw = 1'b0;
      if (cyc == 15) sw_raw = 1'b1;
      if (slide_hold && !prev) begin rises++; if (rise_cyc < 0) rise_cyc = cyc; end
      if (!slide_hold && prev) falls++;
      if (move_left_pulse || move_right_pulse || jump_pulse || start_pulse) n_pulse++;
      prev = slide_hold;
    end
    total++;
    if (rises !== 1) $display("FAIL slide_rises: got %0d expected 1", rises);
    else passed++;
    total++;
    if (falls !== 0) $display("FAIL slide_falls: got %0d expected 0", falls);
    else passed++;
    total++;
    if (rise_cyc !== 10) $display("FAIL slide_rise_cycle: got %0d expected 10", rise_cyc);
    else passed++;
    total++;
    if (slide_hold !== 1'b1) $display("FAIL slide_final: got %b expected 1", slide_hold);
    else passed++;
    total++;
    if (n_pulse !== 0) $display("FAIL slide_pulses: got %0d expected 0", n_pulse);
    else passed++;
    settle();
  endtask

  initial begin
    passed = 0;
    total = 0;
    reset = 1'b1;
    btn_raw = 3'b000;
    sw_raw = 1'b0;
    game_active = 1'b0;
    test_reset();
    test_left_hold();
    test_glitch_right();
    test_start_jump();
    test_simultaneous();
    test_reset_press_wait();
    test_slide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 400000, is the number of stable input cycles required to accept a level change (10 ms at 40 MHz).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth per raw input.
REQ-003 Port `clock`, input, 1 bit: the single 40 MHz pixel/game clock.
REQ-004 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 Port `btn_raw`, input, 3 bits: asynchronous buttons; [0]=left, [1]=right, [2]=start/jump.
REQ-006 Port `sw_raw`, input, 1 bit: asynchronous slide switch.
REQ-007 Port `game_active`, input, 1 bit: game-FSM running flag, used for start/jump steering.
REQ-008 Port `btn_level`, output, 3 bits: debounced button levels.
REQ-009 Port `move_left_pulse`, output, 1 bit: one-cycle pulse on a debounced left press.
REQ-010 Port `move_right_pulse`, output, 1 bit: one-cycle pulse on a debounced right press.
REQ-011 Port `jump_pulse`, output, 1 bit: one-cycle pulse on a debounced start/jump press while game_active=1.
REQ-012 Port `start_pulse`, output, 1 bit: one-cycle pulse on a debounced start/jump press while game_active=0.
REQ-013 Port `slide_hold`, output, 1 bit: debounced sw_raw level.

Function
REQ-014 Each of the 4 raw inputs SHALL pass through a SYNC_STAGES-deep flip-flop synchronizer before any other logic sees it.
REQ-015 Each channel SHALL run a 4-state FSM: IDLE (level 0), PRESS_WAIT, HELD (level 1), RELEASE_WAIT.
REQ-016 IDLE->PRESS_WAIT when the synchronized input is 1; the debounce counter clears on entry.
REQ-017 In PRESS_WAIT the counter SHALL increment each cycle while the input is 1; if the input reads 0 the FSM returns to IDLE and the counter clears.
REQ-018 PRESS_WAIT->HELD on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the input still 1; the level goes to 1 on that transition.
REQ-019 HELD->RELEASE_WAIT and RELEASE_WAIT->IDLE SHALL mirror REQ-016..REQ-018 with polarity inverted; the level goes to 0 on entering IDLE.
REQ-020 Each counter SHALL be ceil(log2(DEBOUNCE_CYCLES)) bits wide and SHALL never wrap; it saturates until the transition occurs.
REQ-021 A press pulse SHALL assert for exactly one cycle, in the cycle after the level rises 0->1; a held button SHALL produce no further pulses.
REQ-022 Total latency from a stable raw edge to its pulse SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
REQ-023 jump_pulse and start_pulse SHALL be steered by the game_active value sampled in the pulse cycle; they SHALL never both be 1.
REQ-024 Left and right pulses on the same cycle SHALL both be output; arbitration belongs to the player block.
REQ-025 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no level change and no pulse.
REQ-026 slide_hold SHALL follow the debounced switch level with no pulse generation.

Reset
REQ-027 On reset all synchronizer flops, levels, counters and pulses SHALL clear to 0, and all FSMs SHALL enter IDLE.
REQ-028 A button held through the deassertion of reset SHALL produce exactly one pulse, DEBOUNCE_CYCLES + SYNC_STAGES + 1 cycles after deassertion.
REQ-029 A reset asserted during PRESS_WAIT SHALL suppress the pending pulse.

Structure
REQ-030 The shared game package SHALL hold the state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT) and the button-index constants (BTN_LEFT=0, BTN_RIGHT=1, BTN_JUMP=2).
REQ-031 One sub-module, `debounce_channel`, SHALL contain the synchronizer, FSM, counter and rising-pulse logic; this block SHALL instantiate it 4 times.
REQ-032 The top level SHALL instantiate this block between the board pins and the player/FSM blocks, replacing its raw edge detection.

Verification (DEBOUNCE_CYCLES=8, SYNC_STAGES=2 in the bench)
REQ-033 Hold btn_raw[0] high for 20 cycles -> exactly one move_left_pulse, 11 cycles after the rise; btn_level[0]=1 until release.
REQ-034 Pulse btn_raw[1] high for 5 cycles, then low -> no move_right_pulse and btn_level[1] stays 0.
REQ-035 Bounce btn_raw[2] (1,0,1,0) then hold high with game_active=0 -> one start_pulse and no jump_pulse; repeat with game_active=1 -> one jump_pulse only.
REQ-036 Hold btn_raw[0] and btn_raw[1] high simultaneously -> move_left_pulse and move_right_pulse assert in the same cycle.
REQ-037 Assert reset in cycle 5 of PRESS_WAIT -> no pulse and all outputs 0; with the button still held after release of reset -> one pulse 11 cycles later.
REQ-038 Toggle sw_raw high for 12 cycles, low for 3 cycles, then high -> slide_hold rises once and stays 1 (the 3-cycle low is rejected).
